// File: rtl/avalon_burst_mem_slave_if.sv
// Avalon-MM command/response bundle between a CPU memory master and the burst memory slave.
interface avalon_burst_mem_slave_if #(
    parameter int p_word_bits = 32,
    parameter int p_addr_bits = 10
);
    logic [p_addr_bits-1:0] i_addr;
    logic                   i_read;
    logic                   i_write;
    logic [p_word_bits-1:0] i_writedata;
    logic [p_word_bits-1:0] i_burstcount;
    logic                   o_waitrequest;
    logic [p_word_bits-1:0] o_readdata;
    logic                   o_readdatavalid;
    logic                   o_cmd_error;

    modport master (
        output i_addr, i_read, i_write, i_writedata, i_burstcount,
        input  o_waitrequest, o_readdata, o_readdatavalid, o_cmd_error
    );

    modport slave (
        input  i_addr, i_read, i_write, i_writedata, i_burstcount,
        output o_waitrequest, o_readdata, o_readdatavalid, o_cmd_error
    );
endinterface

// File: rtl/avalon_burst_mem_slave.sv
// Word-addressed Avalon-MM memory slave: single-word writes, back-to-back burst reads
// with zero-gap chaining, and a host preload port that works in any state.
module avalon_burst_mem_slave #(
    parameter int p_word_bits = 32,
    parameter int p_addr_bits = 10,
    parameter int p_max_burst = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    avalon_burst_mem_slave_if.slave bus,
    input  logic [p_addr_bits-1:0] i_load_addr,
    input  logic [p_word_bits-1:0] i_load_data,
    input  logic                   i_load_write
);
    localparam int cnt_bits = $clog2(p_max_burst + 1);
    localparam int depth    = 1 << p_addr_bits;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
    typedef logic [cnt_bits-1:0]    cnt_t;
    typedef logic [p_addr_bits-1:0] addr_t;

    state_t                 state_q, state_d;
    addr_t                  addr_q;
    cnt_t                   remain_q;
    logic [p_word_bits-1:0] ram [depth];
    logic [p_word_bits-1:0] rdata_q;
    logic                   rvalid_q;
    logic                   err_q;

    logic  bad_count;
    cnt_t  n_eff;
    logic  cmd_rd, cmd_wr;
    logic  beat, err_c;
    addr_t rd_addr;

    // Out-of-range counts collapse to a single beat rather than being rejected.
    always_comb begin
        bad_count = (bus.i_burstcount == '0) ||
                    (bus.i_burstcount > p_word_bits'(p_max_burst));
        n_eff     = bad_count ? cnt_t'(1) : cnt_t'(bus.i_burstcount);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (cmd_rd && n_eff > cnt_t'(1)) state_d = BURST;
            BURST: if (remain_q == cnt_t'(1))       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / command decode; a read+write collision keeps the write and drops the read.
    always_comb begin
        bus.o_waitrequest = (state_q == BURST);
        cmd_wr  = (state_q == IDLE) && bus.i_write;
        cmd_rd  = (state_q == IDLE) && bus.i_read && !bus.i_write;
        err_c   = (state_q == IDLE) && bus.i_read && (bus.i_write || bad_count);
        beat    = cmd_rd || (state_q == BURST);
        rd_addr = (state_q == BURST) ? addr_q : bus.i_addr;
    end

    // Burst address and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            remain_q <= '0;
        end else if (cmd_rd) begin
            addr_q   <= bus.i_addr + addr_t'(1);
            remain_q <= n_eff - cnt_t'(1);
        end else if (state_q == BURST) begin
            addr_q   <= addr_q + addr_t'(1);
            remain_q <= remain_q - cnt_t'(1);
        end
    end

    // Write port: the load is applied last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (cmd_wr)       ram[bus.i_addr] <= bus.i_writedata;
        if (i_load_write) ram[i_load_addr] <= i_load_data;
    end

    // Synchronous read port; sees pre-edge contents, giving read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= beat;
            err_q    <= err_c;
            if (beat) rdata_q <= ram[rd_addr];
        end
    end

    assign bus.o_readdata      = rdata_q;
    assign bus.o_readdatavalid = rvalid_q;
    assign bus.o_cmd_error     = err_q;
endmodule

// File: tb/tb_avalon_burst_mem_slave.sv
// Directed bench for avalon_burst_mem_slave: bursts, wrap, chaining, errors, reset, collisions.
module tb_avalon_burst_mem_slave;
    localparam int WB = 32;
    localparam int AB = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [AB-1:0] load_addr;
    logic [WB-1:0] load_data;
    logic          load_write;
    int            n_cmp = 0;
    int            n_err = 0;

    avalon_burst_mem_slave_if #(.p_word_bits(WB), .p_addr_bits(AB)) bus ();

    avalon_burst_mem_slave #(.p_word_bits(WB), .p_addr_bits(AB), .p_max_burst(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .i_load_addr  (load_addr),
        .i_load_data  (load_data),
        .i_load_write (load_write)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input logic [WB-1:0] d);
        load_addr = AB'(a); load_data = d; load_write = 1'b1;
        tick();
        load_write = 1'b0;
    endtask

    task automatic issue_read(input int a, input int n);
        bus.i_addr = AB'(a); bus.i_burstcount = WB'(n); bus.i_read = 1'b1;
        tick();
        bus.i_read = 1'b0;
    endtask

    initial begin
        logic [WB-1:0] exp_d;
        rst = 1'b1; load_write = 1'b0; load_addr = '0; load_data = '0;
        bus.i_addr = '0; bus.i_read = 1'b0; bus.i_write = 1'b0;
        bus.i_writedata = '0; bus.i_burstcount = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_wait",  WB'(bus.o_waitrequest),   0);
        chk("rst_valid", WB'(bus.o_readdatavalid), 0);
        chk("rst_data",  bus.o_readdata,           0);
        chk("rst_err",   WB'(bus.o_cmd_error),     0);

        for (int i = 0; i < 8; i++) load(i, WB'(32'h10 + i));
        for (int i = 0; i < 4; i++) load(8 + i, WB'(32'h20 + i));
        load(1022, 32'hA0);
        load(1023, 32'hA1);

        // 8-beat burst from 0
        issue_read(0, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b8_valid%0d", i), WB'(bus.o_readdatavalid), 1);
            chk($sformatf("b8_data%0d", i),  bus.o_readdata, WB'(32'h10 + i));
            chk($sformatf("b8_wait%0d", i),  WB'(bus.o_waitrequest), (i < 7) ? 1 : 0);
            tick();
        end
        chk("b8_end_valid", WB'(bus.o_readdatavalid), 0);
        chk("b8_end_wait",  WB'(bus.o_waitrequest),   0);

        // single write then single read
        bus.i_addr = AB'(5); bus.i_writedata = 32'hDEADBEEF; bus.i_write = 1'b1;
        tick();
        bus.i_write = 1'b0;
        chk("wr_novalid", WB'(bus.o_readdatavalid), 0);
        chk("wr_wait",    WB'(bus.o_waitrequest),   0);
        issue_read(5, 1);
        chk("rd1_valid", WB'(bus.o_readdatavalid), 1);
        chk("rd1_data",  bus.o_readdata, 32'hDEADBEEF);
        chk("rd1_wait",  WB'(bus.o_waitrequest), 0);
        tick();
        chk("rd1_after_valid", WB'(bus.o_readdatavalid), 0);
        chk("rd1_hold_data",   bus.o_readdata, 32'hDEADBEEF);

        // wrap past top address
        issue_read(1022, 4);
        chk("wrap0", bus.o_readdata, 32'hA0); tick();
        chk("wrap1", bus.o_readdata, 32'hA1); tick();
        chk("wrap2", bus.o_readdata, 32'h10); tick();
        chk("wrap3", bus.o_readdata, 32'h11);
        chk("wrap3_valid", WB'(bus.o_readdatavalid), 1);
        tick();
        chk("wrap_end_valid", WB'(bus.o_readdatavalid), 0);

        // chained bursts: second command issued in the last-beat cycle
        issue_read(0, 4);
        for (int i = 0; i < 8; i++) begin
            exp_d = (i < 4) ? WB'(32'h10 + i) : WB'(32'h20 + i - 4);
            chk($sformatf("chain_valid%0d", i), WB'(bus.o_readdatavalid), 1);
            chk($sformatf("chain_data%0d", i),  bus.o_readdata, exp_d);
            chk($sformatf("chain_wait%0d", i),  WB'(bus.o_waitrequest), (i == 3 || i == 7) ? 0 : 1);
            if (i == 3) issue_read(8, 4);
            else        tick();
        end
        chk("chain_end_valid", WB'(bus.o_readdatavalid), 0);

        // burstcount 0 -> one beat + error
        issue_read(2, 0);
        chk("bc0_valid", WB'(bus.o_readdatavalid), 1);
        chk("bc0_data",  bus.o_readdata, 32'h12);
        chk("bc0_err",   WB'(bus.o_cmd_error), 1);
        chk("bc0_wait",  WB'(bus.o_waitrequest), 0);
        tick();
        chk("bc0_err_clr",  WB'(bus.o_cmd_error), 0);
        chk("bc0_valid_clr", WB'(bus.o_readdatavalid), 0);

        // burstcount 9 -> one beat + error
        issue_read(3, 9);
        chk("bc9_valid", WB'(bus.o_readdatavalid), 1);
        chk("bc9_data",  bus.o_readdata, 32'h13);
        chk("bc9_err",   WB'(bus.o_cmd_error), 1);
        chk("bc9_wait",  WB'(bus.o_waitrequest), 0);
        tick();
        chk("bc9_err_clr",   WB'(bus.o_cmd_error), 0);
        chk("bc9_valid_clr", WB'(bus.o_readdatavalid), 0);

        // read+write together: write wins, no beat, error
        bus.i_addr = AB'(6); bus.i_writedata = 32'hCAFE0006; bus.i_burstcount = WB'(1);
        bus.i_read = 1'b1; bus.i_write = 1'b1;
        tick();
        bus.i_read = 1'b0; bus.i_write = 1'b0;
        chk("rw_valid", WB'(bus.o_readdatavalid), 0);
        chk("rw_err",   WB'(bus.o_cmd_error), 1);
        tick();
        chk("rw_err_clr", WB'(bus.o_cmd_error), 0);
        issue_read(6, 1);
        chk("rw_data", bus.o_readdata, 32'hCAFE0006);
        chk("rw_readback_err", WB'(bus.o_cmd_error), 0);

        // reset after the 2nd beat of an 8-beat burst
        issue_read(0, 8);
        chk("rb_beat0", bus.o_readdata, 32'h10); tick();
        chk("rb_beat1", bus.o_readdata, 32'h11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rb_valid", WB'(bus.o_readdatavalid), 0);
        chk("rb_wait",  WB'(bus.o_waitrequest),   0);
        tick();
        chk("rb_valid2", WB'(bus.o_readdatavalid), 0);
        issue_read(3, 1);
        chk("rb_rd_valid", WB'(bus.o_readdatavalid), 1);
        chk("rb_rd_data",  bus.o_readdata, 32'h13);

        // load beats a bus write to the same address
        bus.i_addr = AB'(9); bus.i_writedata = 32'h1111; bus.i_write = 1'b1;
        load_addr = AB'(9); load_data = 32'h2222; load_write = 1'b1;
        tick();
        bus.i_write = 1'b0; load_write = 1'b0;
        issue_read(9, 1);
        chk("ld_wins", bus.o_readdata, 32'h2222);

        // read-before-write on a load to the same address
        load_addr = AB'(10); load_data = 32'h3333; load_write = 1'b1;
        issue_read(10, 1);
        load_write = 1'b0;
        chk("rbw_old", bus.o_readdata, 32'h22);
        issue_read(10, 1);
        chk("rbw_new", bus.o_readdata, 32'h3333);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
